// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-file geometry and the
// basic word / register-number types used across the datapath.
package cpu_pkg;

    // Register-number width and data width of the general-purpose register file.
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    // Hard-wired zero register.
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_num_t;
    typedef logic [REG_DW-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/rf_wr_dec.sv
// Register-file write-select decoder: AW-bit register number to a
// one-hot row-enable vector, gated by a single enable. Purely combinational.
module rf_wr_dec #(
    parameter int AW = 5
) (
    input  logic                 en_i,
    input  logic [AW-1:0]        addr_i,
    output logic [(2**AW)-1:0]   row_o
);

    // One-hot decode: exactly one row high when enabled, none otherwise.
    always_comb begin
        // NOTE: every output gets a default before the conditional update,
        // otherwise the untaken path would hold its old value and infer a latch.
        row_o = '0;
        if (en_i) begin
            row_o[addr_i] = 1'b1;
        end
    end

endmodule : rf_wr_dec

// File: rtl/reg_file_wb.sv
// 32-entry general-purpose register file with a one-entry write-back
// staging register. A write is captured on one edge and committed to the
// array on the next; both read ports forward from the staging register so
// a captured write is visible immediately. Register 0 is hard-wired to zero.
module reg_file_wb
    import cpu_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          We,
    input  logic [AW-1:0] Wn,
    input  logic [DW-1:0] D,
    input  logic [AW-1:0] Rna,
    input  logic [AW-1:0] Rnb,
    output logic [DW-1:0] Qa,
    output logic [DW-1:0] Qb,
    output logic          Pend,
    output logic [AW-1:0] Pn
);

    localparam int NREG = 2**AW;

    // Write-back staging register.
    logic          stage_v_q, stage_v_d;
    logic [AW-1:0] stage_n_q, stage_n_d;
    logic [DW-1:0] stage_d_q, stage_d_d;

    // Row enables from the write decoder; row 0 has no storage behind it.
    logic [NREG-1:0] en_row;
    logic            unused_row0;

    // Architectural registers 1..NREG-1; register 0 is not stored.
    logic [DW-1:0] regs_q [NREG-1:1];

    // Next staging contents: writes to register 0 are dropped here so they
    // never show as pending and never reach the array.
    always_comb begin
        stage_v_d = We && (Wn != '0);
        stage_n_d = Wn;
        stage_d_d = D;
    end

    // Capture the incoming write request into the staging register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stage_v_q <= 1'b0;
            stage_n_q <= '0;
            stage_d_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let the commit block below read
            // the old stage_d_q on the same edge the new request is captured,
            // regardless of the order the simulator evaluates the blocks.
            stage_v_q <= stage_v_d;
            stage_n_q <= stage_n_d;
            stage_d_q <= stage_d_d;
        end
    end

    // Decode the staged register number into one-hot row enables.
    rf_wr_dec #(
        .AW (AW)
    ) u_wr_dec (
        .en_i   (stage_v_q),
        .addr_i (stage_n_q),
        .row_o  (en_row)
    );

    // Row 0 can never be selected (stage_v is cleared for it) and has no storage.
    assign unused_row0 = en_row[0];

    // Commit the staged write into the selected array row.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: the array is cleared on reset because every register must
            // read zero after reset; this keeps it in flops rather than RAM.
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (en_row[i]) begin
                    regs_q[i] <= stage_d_q;
                end
            end
        end
    end

    // Read muxes: zero register, then forward from staging, then the array.
    // Only staged data is forwarded; D itself never reaches the outputs.
    always_comb begin
        Qa = '0;
        if (Rna != '0) begin
            if (stage_v_q && (stage_n_q == Rna)) begin
                Qa = stage_d_q;
            end else begin
                Qa = regs_q[Rna];
            end
        end

        Qb = '0;
        if (Rnb != '0) begin
            if (stage_v_q && (stage_n_q == Rnb)) begin
                Qb = stage_d_q;
            end else begin
                Qb = regs_q[Rnb];
            end
        end
    end

    // Pending-write status straight from the staging register.
    always_comb begin
        Pend = stage_v_q;
        Pn   = stage_n_q;
    end

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// Testbench for reg_file_wb: directed vectors drive the inputs and push the
// hand-computed expected read/status values into a scoreboard queue; an
// independent monitor pops and compares them at the falling clock edge.
module tb_reg_file_wb;
    import cpu_pkg::*;

    logic     Clk = 1'b0;
    logic     Rst;
    logic     We;
    reg_num_t Wn;
    word_t    D;
    reg_num_t Rna;
    reg_num_t Rnb;
    word_t    Qa;
    word_t    Qb;
    logic     Pend;
    reg_num_t Pn;

    reg_file_wb #(
        .DW (REG_DW),
        .AW (REG_AW)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .We   (We),
        .Wn   (Wn),
        .D    (D),
        .Rna  (Rna),
        .Rnb  (Rnb),
        .Qa   (Qa),
        .Qb   (Qb),
        .Pend (Pend),
        .Pn   (Pn)
    );

    always #5 Clk = ~Clk;

    // Expected observation for one cycle; c* flags select which fields are compared.
    typedef struct {
        string    name;
        int       cyc;
        bit       ca;
        word_t    qa;
        bit       cb;
        word_t    qb;
        bit       cp;
        bit       pend;
        bit       cn;
        reg_num_t pn;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: at each falling edge compare every expectation stamped for this cycle.
    initial forever begin
        @(negedge Clk);
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                check({e.name, "_stale"}, cyc, e.cyc);
            end else begin
                if (e.ca) check({e.name, "_qa"}, Qa, e.qa);
                if (e.cb) check({e.name, "_qb"}, Qb, e.qb);
                if (e.cp) check({e.name, "_pend"}, {31'b0, Pend}, {31'b0, e.pend});
                if (e.cn) check({e.name, "_pn"}, 32'(Pn), 32'(e.pn));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit we, input reg_num_t wn, input word_t d,
                         input reg_num_t ra, input reg_num_t rb);
        We  = we;
        Wn  = wn;
        D   = d;
        Rna = ra;
        Rnb = rb;
    endtask

    task automatic expect_rd(input string name,
                             input bit ca, input word_t qa,
                             input bit cb, input word_t qb,
                             input bit cp, input bit pend,
                             input bit cn, input reg_num_t pn);
        exp_t e;
        e.name = name; e.cyc = cyc;
        e.ca = ca; e.qa = qa;
        e.cb = cb; e.qb = qb;
        e.cp = cp; e.pend = pend;
        e.cn = cn; e.pn = pn;
        sb_q.push_back(e);
    endtask

    function automatic word_t val(input int n);
        return word_t'(n) * 32'h0101_0101;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        Rst = 1'b1;
        drive(0, 5'd0, '0, 5'd5, 5'd31);
        repeat (2) tick();
        expect_rd("rst_state", 1, '0, 1, '0, 1, 0, 1, 5'd0);
        tick();
        Rst = 1'b0;

        // Preload r5 and r31, then reset asynchronously between edges.
        drive(1, 5'd5, 32'h55, 5'd5, 5'd31);
        expect_rd("pre_old", 1, '0, 1, '0, 1, 0, 0, 5'd0);
        tick();
        drive(1, 5'd31, 32'h3131, 5'd5, 5'd31);
        expect_rd("pre_fwd5", 1, 32'h55, 1, '0, 1, 1, 1, 5'd5);
        tick();
        drive(0, 5'd0, '0, 5'd5, 5'd31);
        expect_rd("pre_fwd31", 1, 32'h55, 1, 32'h3131, 1, 1, 1, 5'd31);
        tick();
        expect_rd("pre_done", 1, 32'h55, 1, 32'h3131, 1, 0, 0, 5'd0);
        tick();
        Rst = 1'b1;
        expect_rd("rst_async", 1, '0, 1, '0, 1, 0, 1, 5'd0);
        tick();
        Rst = 1'b0;
        expect_rd("rst_rel_a", 1, '0, 1, '0, 1, 0, 0, 5'd0);
        tick();
        expect_rd("rst_rel_b", 1, '0, 1, '0, 1, 0, 0, 5'd0);
        tick();

        // Write / forward / commit of r7.
        drive(1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0);
        expect_rd("wr7_old", 1, '0, 0, '0, 1, 0, 0, 5'd0);
        tick();
        drive(0, 5'd0, '0, 5'd7, 5'd0);
        expect_rd("wr7_fwd", 1, 32'hDEADBEEF, 0, '0, 1, 1, 1, 5'd7);
        tick();
        expect_rd("wr7_commit", 1, 32'hDEADBEEF, 0, '0, 1, 0, 0, 5'd0);
        tick();

        // Register 0 protection.
        drive(1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        expect_rd("r0_req", 1, '0, 1, '0, 1, 0, 0, 5'd0);
        tick();
        drive(0, 5'd0, '0, 5'd0, 5'd0);
        expect_rd("r0_cap", 1, '0, 1, '0, 1, 0, 1, 5'd0);
        tick();
        expect_rd("r0_after", 1, '0, 1, '0, 1, 0, 0, 5'd0);
        tick();

        // Back-to-back writes to r3: the later value wins.
        drive(1, 5'd3, 32'h11, 5'd0, 5'd3);
        expect_rd("b2b_old", 0, '0, 1, '0, 1, 0, 0, 5'd0);
        tick();
        drive(1, 5'd3, 32'h22, 5'd0, 5'd3);
        expect_rd("b2b_k", 0, '0, 1, 32'h11, 1, 1, 1, 5'd3);
        tick();
        drive(0, 5'd0, '0, 5'd0, 5'd3);
        expect_rd("b2b_k1", 0, '0, 1, 32'h22, 1, 1, 1, 5'd3);
        tick();
        expect_rd("b2b_k2", 0, '0, 1, 32'h22, 1, 0, 0, 5'd0);
        tick();

        // Fill r1..r31 on consecutive edges, forwarding the previous write on port A.
        for (int n = 1; n < 32; n++) begin
            drive(1, reg_num_t'(n), val(n), reg_num_t'(n - 1), 5'd0);
            expect_rd("fill_fwd", 1, (n > 1) ? val(n - 1) : '0, 0, '0,
                      1, (n > 1), (n > 1), reg_num_t'(n - 1));
            tick();
        end
        drive(0, 5'd0, '0, 5'd31, 5'd1);
        expect_rd("fill_last", 1, val(31), 1, val(1), 1, 1, 1, 5'd31);
        tick();
        expect_rd("fill_drain", 1, val(31), 1, val(1), 1, 0, 0, 5'd0);
        tick();

        // Dual-port readback, including both ports on r16 together.
        for (int n = 1; n < 32; n++) begin
            drive(0, 5'd0, '0, reg_num_t'(n), reg_num_t'(32 - n));
            expect_rd("dual", 1, val(n), 1, val(32 - n), 1, 0, 0, 5'd0);
            tick();
        end

        // Reset while a write to r9 is pending: the write is discarded.
        drive(1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd0);
        expect_rd("mid_old", 1, val(9), 0, '0, 1, 0, 0, 5'd0);
        tick();
        drive(0, 5'd0, '0, 5'd9, 5'd0);
        expect_rd("mid_fwd", 1, 32'hA5A5A5A5, 0, '0, 1, 1, 1, 5'd9);
        @(negedge Clk);
        #1;
        Rst = 1'b1;
        tick();
        expect_rd("mid_rst", 1, '0, 0, '0, 1, 0, 1, 5'd0);
        tick();
        Rst = 1'b0;
        expect_rd("mid_rel", 1, '0, 0, '0, 1, 0, 0, 5'd0);
        tick();
        expect_rd("mid_rel2", 1, '0, 0, '0, 1, 0, 0, 5'd0);
        tick();

        // Let the monitor drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() != 0) check("sb_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_wb
